ps2_cmd_ctrl: RTL
=================

PS2_CMD_CTRL -- requirements
Module: ps2_cmd_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 1000000, meaning the maximum number of cycles the block waits after a prefix byte (E0/F0) before abandoning the sequence.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port byte_valid, input, 1 bit: one-cycle strobe marking a new scan-code byte from the PS/2 scanner.
REQ-005 SHALL have port byte_in, input, 8 bits: scan-code byte, sampled only when byte_valid=1.
REQ-006 SHALL have port cmd_valid, output, 1 bit: one-cycle strobe marking a score command.
REQ-007 SHALL have port cmd_team, output, 1 bit: team select, 0=Guest, 1=Home; valid with cmd_valid.
REQ-008 SHALL have port cmd_sub, output, 1 bit: operation select, 0=add, 1=subtract; valid with cmd_valid.
REQ-009 SHALL have port cmd_amt, output, 2 bits: point amount, 1..3; valid with cmd_valid.
REQ-010 SHALL have port pause_pulse, output, 1 bit: one-cycle strobe that toggles the game clock.
REQ-011 SHALL have port seq_err, output, 1 bit: one-cycle strobe raised on a prefix timeout.

Function
REQ-012 SHALL implement FSM states IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
REQ-013 SHALL make these IDLE transitions: byte E0 -> EXT; byte F0 -> BRK; any other byte is a make code and stays in IDLE.
REQ-014 SHALL make these EXT transitions: byte F0 -> EXT_BRK; any other byte -> IDLE with no command issued (extended keys are ignored).
REQ-015 SHALL make these BRK/EXT_BRK transitions: the next byte is a break code -> IDLE; an EXT_BRK break is discarded.
REQ-016 SHALL use this make-code map: Guest add 16/1E/26 = 1/2/3; Guest sub 15/1D/24 = 1/2/3; Home add 3E/46/45 = 1/2/3; Home sub 43/44/4D = 1/2/3; 29 = pause.
REQ-017 SHALL assert cmd_valid or pause_pulse exactly one cycle after the byte_valid cycle carrying a mapped make code, for one cycle only, and not for unmapped codes.
REQ-018 SHALL hold cmd_team, cmd_sub and cmd_amt at their last issued values whenever cmd_valid=0.
REQ-019 SHALL suppress typematic repeats: track one held key (held_code, held_vld), and when a make equals held_code with held_vld=1, issue nothing.
REQ-020 SHALL, on an issued mapped make, load held_code with the code and set held_vld=1, with a new distinct key replacing the held key (rollover).
REQ-021 SHALL clear held_vld on a non-extended break matching held_code; any other break code SHALL leave it unchanged.
REQ-022 SHALL count cycles in EXT, BRK and EXT_BRK, clearing the count on every byte_valid.
REQ-023 SHALL, when the count reaches TIMEOUT_CYC, return to IDLE, pulse seq_err for one cycle, and clear held_vld.
REQ-024 SHALL process every byte_valid, including back-to-back cycles, with no bytes dropped, and SHALL NOT stall.
REQ-025 SHALL process a byte_valid arriving in the same cycle the timeout fires as a byte received in IDLE.
REQ-026 SHALL assert at most one of cmd_valid, pause_pulse, seq_err in any cycle.

Reset
REQ-027 SHALL, while reset=0, force state IDLE, held_vld=0, held_code=00, timeout count 0, cmd_valid=0, pause_pulse=0, seq_err=0, cmd_team=0, cmd_sub=0, cmd_amt=0.
REQ-028 SHALL abandon a partial sequence if reset is asserted mid-sequence, with no output pulse, and SHALL treat the first byte after release as received in IDLE.

Verification
REQ-029 SHALL cover: bytes 1E, F0, 1E -> one cmd_valid (team 0, sub 0, amt 2) one cycle after the first byte; none for F0 or the second 1E.
REQ-030 SHALL cover: bytes 4D, 4D, 4D, F0, 4D, 4D -> exactly two cmd_valid (team 1, sub 1, amt 3): on the first byte and on the last byte.
REQ-031 SHALL cover: bytes E0, 29, E0, F0, 29 -> no pause_pulse; bytes 29, F0, 29 -> exactly one pause_pulse.
REQ-032 SHALL cover: byte F0, then TIMEOUT_CYC idle cycles -> seq_err pulse; a following 16 -> cmd_valid (team 0, sub 0, amt 1).
REQ-033 SHALL cover: bytes 16, 3E on consecutive cycles -> cmd_valid on two consecutive cycles, Guest+1 then Home+1.
REQ-034 SHALL cover: E0 then reset pulse then 24 -> no output during reset; cmd_valid (team 0, sub 1, amt 3) after 24.

Source files
------------

// File: rtl/ps2_cmd_ctrl.sv
// PS/2 scan-code to scoreboard command translator.
// Tracks E0/F0 prefixes, suppresses typematic repeats, times out stale prefixes.
module ps2_cmd_ctrl #(
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       byte_valid,
  input  logic [7:0] byte_in,
  output logic       cmd_valid,
  output logic       cmd_team,
  output logic       cmd_sub,
  output logic [1:0] cmd_amt,
  output logic       pause_pulse,
  output logic       seq_err
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } state_t;

  state_t      state, state_d, cur;
  logic [CW-1:0] cnt, cnt_d;
  logic [7:0]  held_code, held_d;
  logic        held_vld, hv_cur, hv_d;
  logic        tout;
  logic        hit, is_pause, m_team, m_sub;
  logic [1:0]  m_amt;
  logic        cv_d, pp_d, team_d, sub_d;
  logic [1:0]  amt_d;

  always_comb begin
    hit      = 1'b1;
    is_pause = 1'b0;
    m_team   = 1'b0;
    m_sub    = 1'b0;
    m_amt    = 2'd0;
    case (byte_in)
      8'h16: m_amt = 2'd1;
      8'h1E: m_amt = 2'd2;
      8'h26: m_amt = 2'd3;
      8'h15: begin m_sub = 1'b1; m_amt = 2'd1; end
      8'h1D: begin m_sub = 1'b1; m_amt = 2'd2; end
      8'h24: begin m_sub = 1'b1; m_amt = 2'd3; end
      8'h3E: begin m_team = 1'b1; m_amt = 2'd1; end
      8'h46: begin m_team = 1'b1; m_amt = 2'd2; end
      8'h45: begin m_team = 1'b1; m_amt = 2'd3; end
      8'h43: begin
        m_team = 1'b1; m_sub = 1'b1; m_amt = 2'd1;
      end
      8'h44: begin
        m_team = 1'b1; m_sub = 1'b1; m_amt = 2'd2;
      end
      8'h4D: begin
        m_team = 1'b1; m_sub = 1'b1; m_amt = 2'd3;
      end
      8'h29: is_pause = 1'b1;
      default: hit = 1'b0;
    endcase
  end

  // A timeout makes this cycle behave as IDLE, so a coincident byte is kept.
  assign tout    = (state != IDLE) && (cnt == TMAX);
  assign seq_err = tout;
  assign cur     = tout ? IDLE : state;
  assign hv_cur  = tout ? 1'b0 : held_vld;

  always_comb begin
    state_d = cur;
    held_d  = held_code;
    hv_d    = hv_cur;
    cv_d    = 1'b0;
    pp_d    = 1'b0;
    team_d  = cmd_team;
    sub_d   = cmd_sub;
    amt_d   = cmd_amt;
    if (byte_valid) begin
      unique case (cur)
        IDLE: begin
          if (byte_in == 8'hE0) begin
            state_d = EXT;
          end else if (byte_in == 8'hF0) begin
            state_d = BRK;
          end else if (hit && !(hv_cur && held_code == byte_in)) begin
            held_d = byte_in;
            hv_d   = 1'b1;
            if (is_pause) begin
              pp_d = 1'b1;
            end else begin
              cv_d   = 1'b1;
              team_d = m_team;
              sub_d  = m_sub;
              amt_d  = m_amt;
            end
          end
        end
        EXT: state_d = (byte_in == 8'hF0) ? EXT_BRK : IDLE;
        BRK: begin
          state_d = IDLE;
          if (hv_cur && held_code == byte_in) hv_d = 1'b0;
        end
        EXT_BRK: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    cnt_d = (byte_valid || cur == IDLE) ? '0 : cnt + CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      held_code   <= 8'h00;
      held_vld    <= 1'b0;
      cmd_valid   <= 1'b0;
      pause_pulse <= 1'b0;
      cmd_team    <= 1'b0;
      cmd_sub     <= 1'b0;
      cmd_amt     <= 2'd0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      held_code   <= held_d;
      held_vld    <= hv_d;
      cmd_valid   <= cv_d;
      pause_pulse <= pp_d;
      cmd_team    <= team_d;
      cmd_sub     <= sub_d;
      cmd_amt     <= amt_d;
    end
  end

endmodule
